// File: rtl/uart_rx_ctrl.sv
`default_nettype none
// ============================================================================
// uart_rx_ctrl : UART receive sequencer (start detect, data/parity/stop sampling)
// Optional macro UART_RX_MAJORITY_EN selects 2-of-3 majority sampling.
// Revision: 1.0
// ============================================================================
module uart_rx_ctrl #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16,
  parameter int PARITY_EN  = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 baud_tick,
  input  logic                 rx_in,
  output logic                 sampled_bit,
  output logic                 data_shift_en,
  output logic                 parity_check_en,
  output logic                 stop_check_en,
  output logic [DATA_BITS-1:0] rx_data,
  output logic                 rx_done,
  output logic                 rx_busy,
  output logic                 false_start
);

  localparam int c_cnt_w = $clog2(OVERSAMPLE);
  localparam int c_bit_w = $clog2(DATA_BITS + 1);
`ifdef UART_RX_MAJORITY_EN
  localparam int c_maj_dly = 1;
`else
  localparam int c_maj_dly = 0;
`endif
  // Only START carries the majority offset; later states inherit it through
  // their delayed entry, so every sample stays exactly one bit period apart.
  localparam logic [c_cnt_w-1:0] c_term_start = c_cnt_w'(OVERSAMPLE / 2 - 1 + c_maj_dly);
  localparam logic [c_cnt_w-1:0] c_term_bit   = c_cnt_w'(OVERSAMPLE - 1);
  localparam logic [c_bit_w-1:0] c_last_bit   = c_bit_w'(DATA_BITS - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t               r_state;
  state_t               w_next_state;
  logic [c_cnt_w-1:0]   r_tick_cnt;
  logic [c_bit_w-1:0]   r_bit_cnt;
  logic [DATA_BITS-1:0] r_shift;
  logic [c_cnt_w-1:0]   w_term;
  logic                 w_sample_pt;
  logic                 w_sample_val;
  logic                 w_shift_en;
  logic                 w_parity_en;
  logic                 w_stop_en;
  logic                 w_false_start;

`ifdef UART_RX_MAJORITY_EN
  logic r_hist_old;
  logic r_hist_new;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_hist_old <= 1'b1;
      r_hist_new <= 1'b1;
    end else if (baud_tick) begin
      r_hist_old <= r_hist_new;
      r_hist_new <= rx_in;
    end
  end

  assign w_sample_val = (r_hist_old & r_hist_new) | (r_hist_old & rx_in) | (r_hist_new & rx_in);
`else
  assign w_sample_val = rx_in;
`endif

  assign w_term      = (r_state == S_START) ? c_term_start : c_term_bit;
  assign w_sample_pt = baud_tick && (r_state != S_IDLE) && (r_tick_cnt == w_term);
  assign rx_busy     = (r_state != S_IDLE);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state  = r_state;
    w_shift_en    = 1'b0;
    w_parity_en   = 1'b0;
    w_stop_en     = 1'b0;
    w_false_start = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (baud_tick && !rx_in) begin
          w_next_state = S_START;
        end
      end
      S_START: begin
        if (w_sample_pt) begin
          if (w_sample_val) begin
            w_next_state  = S_IDLE;
            w_false_start = 1'b1;
          end else begin
            w_next_state = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (w_sample_pt) begin
          w_shift_en = 1'b1;
          if (r_bit_cnt == c_last_bit) begin
            w_next_state = (PARITY_EN != 0) ? S_PARITY : S_STOP;
          end
        end
      end
      S_PARITY: begin
        if (w_sample_pt) begin
          w_parity_en  = 1'b1;
          w_next_state = S_STOP;
        end
      end
      S_STOP: begin
        if (w_sample_pt) begin
          w_stop_en    = 1'b1;
          w_next_state = S_IDLE;
        end
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // State changes only happen in IDLE or at a sample point, so clearing
  // there also covers every state transition.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_tick_cnt <= '0;
    end else if (baud_tick) begin
      if ((r_state == S_IDLE) || w_sample_pt) begin
        r_tick_cnt <= '0;
      end else begin
        r_tick_cnt <= r_tick_cnt + c_cnt_w'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_bit_cnt <= '0;
      r_shift   <= '0;
    end else begin
      if (r_state == S_START) begin
        r_bit_cnt <= '0;
      end else if (w_shift_en) begin
        r_bit_cnt <= r_bit_cnt + c_bit_w'(1);
      end
      if (w_shift_en) begin
        r_shift <= {w_sample_val, r_shift[DATA_BITS-1:1]};
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sampled_bit     <= 1'b1;
      data_shift_en   <= 1'b0;
      parity_check_en <= 1'b0;
      stop_check_en   <= 1'b0;
      rx_done         <= 1'b0;
      false_start     <= 1'b0;
      rx_data         <= '0;
    end else begin
      if (w_sample_pt) begin
        sampled_bit <= w_sample_val;
      end
      data_shift_en   <= w_shift_en;
      parity_check_en <= w_parity_en;
      stop_check_en   <= w_stop_en;
      rx_done         <= w_stop_en;
      false_start     <= w_false_start;
      if (w_stop_en) begin
        rx_data <= r_shift;
      end
    end
  end

endmodule
`default_nettype wire
